// File: rtl/frame_sync_tracker.sv
// Frame sync tracker: hunts for a periodic sync word, verifies it, locks and emits payload words.
// Optional frame counter is built only when FRAME_SYNC_CNT_EN is defined; otherwise frame_cnt is tied to 0.
module frame_sync_tracker #(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned FRAME_WORDS = 16,
    parameter int unsigned LOCK_COUNT  = 3,
    parameter int unsigned MISS_COUNT  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_SIZE-1:0]           i,
    input  logic                           match,
    output logic [DATA_SIZE-1:0]           o,
    output logic                           o_valid,
    output logic                           sof,
    output logic [$clog2(FRAME_WORDS)-1:0] word_idx,
    output logic                           locked,
    output logic                           lock_lost,
    output logic [15:0]                    frame_cnt
);
    localparam int unsigned PW = $clog2(FRAME_WORDS);
    localparam int unsigned HW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MW = $clog2(MISS_COUNT + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        pos_q, pos_d, pos_inc;
    logic [HW-1:0]        hits_q, hits_d, hits_inc;
    logic [MW-1:0]        misses_q, misses_d, misses_inc;
    logic [DATA_SIZE-1:0] o_q, o_d;
    logic                 o_valid_q, o_valid_d;
    logic                 sof_q, sof_d;
    logic [PW-1:0]        word_idx_q, word_idx_d;
    logic                 locked_q, locked_d;
    logic                 lock_lost_q, lock_lost_d;
    logic                 at_sync;

    assign at_sync    = (pos_q == '0);
    assign pos_inc    = (pos_q == PW'(FRAME_WORDS - 1)) ? '0 : pos_q + PW'(1);
    assign hits_inc   = hits_q + HW'(1);
    assign misses_inc = misses_q + MW'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
        lock_lost_d = 1'b0;
        o_d         = o_q;
        o_valid_d   = 1'b0;
        sof_d       = 1'b0;
        word_idx_d  = word_idx_q;

        unique case (state_q)
            HUNT: begin
                if (match) begin
                    pos_d    = PW'(1);
                    hits_d   = HW'(1);
                    misses_d = '0;
                    state_d  = (LOCK_COUNT == 1) ? LOCK : VERIFY;
                end
            end
            VERIFY: begin
                pos_d = pos_inc;
                if (at_sync) begin
                    if (match) begin
                        hits_d = hits_inc;
                        if (hits_inc == HW'(LOCK_COUNT)) begin
                            state_d  = LOCK;
                            misses_d = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        pos_d   = '0;
                    end
                end
            end
            LOCK: begin
                pos_d = pos_inc;
                if (at_sync) begin
                    if (match) begin
                        misses_d = '0;
                    end else begin
                        misses_d = misses_inc;
                        if (misses_inc == MW'(MISS_COUNT)) begin
                            state_d     = HUNT;
                            pos_d       = '0;
                            lock_lost_d = 1'b1;
                        end
                    end
                end else begin
                    o_d        = i;
                    o_valid_d  = 1'b1;
                    word_idx_d = pos_q;
                    sof_d      = (pos_q == PW'(1));
                end
            end
            default: begin
                state_d = HUNT;
                pos_d   = '0;
            end
        endcase

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            pos_q       <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            o_q         <= '0;
            o_valid_q   <= 1'b0;
            sof_q       <= 1'b0;
            word_idx_q  <= '0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            o_q         <= o_d;
            o_valid_q   <= o_valid_d;
            sof_q       <= sof_d;
            word_idx_q  <= word_idx_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign o         = o_q;
    assign o_valid   = o_valid_q;
    assign sof       = sof_q;
    assign word_idx  = word_idx_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;

`ifdef FRAME_SYNC_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // Counts every frame boundary seen in lock, hit or flywheeled; cleared on loss of lock
    always_comb begin
        fcnt_d = fcnt_q;
        if (state_q == LOCK && at_sync) begin
            if (lock_lost_d) begin
                fcnt_d = '0;
            end else if (fcnt_q != 16'hFFFF) begin
                fcnt_d = fcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_sync_tracker.sv
// Scoreboard bench for frame_sync_tracker (FRAME_WORDS=4, LOCK_COUNT=3, MISS_COUNT=2).
module tb_frame_sync_tracker;
    localparam int unsigned DW = 32;
    localparam int unsigned FW = 4;
    localparam int unsigned LC = 3;
    localparam int unsigned MC = 2;
`ifdef FRAME_SYNC_CNT_EN
    localparam int FC_STEP = 1;
`else
    localparam int FC_STEP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, match;
    logic [DW-1:0] i, o;
    logic          o_valid, sof, locked, lock_lost;
    logic [1:0]    word_idx;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    frame_sync_tracker #(
        .DATA_SIZE(DW), .FRAME_WORDS(FW), .LOCK_COUNT(LC), .MISS_COUNT(MC)
    ) dut (
        .clk(clk), .rst(rst), .i(i), .match(match), .o(o), .o_valid(o_valid),
        .sof(sof), .word_idx(word_idx), .locked(locked), .lock_lost(lock_lost),
        .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [31:0] o;
        logic        v;
        logic        sof;
        logic [1:0]  idx;
        logic        lk;
        logic        ll;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    int   m_st, m_pos, m_hits, m_miss, m_fc;
    exp_t m_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    // Behavioural reference: states 0=hunt 1=verify 2=lock
    task automatic model_step(input bit r, input bit m, input logic [31:0] d);
        if (r) begin
            m_st = 0; m_pos = 0; m_hits = 0; m_miss = 0; m_fc = 0;
            m_out = '0;
            return;
        end
        m_out.ll  = 1'b0;
        m_out.v   = 1'b0;
        m_out.sof = 1'b0;
        if (m_st == 2 && m_pos != 0) begin
            m_out.o   = d;
            m_out.v   = 1'b1;
            m_out.idx = 2'(m_pos);
            m_out.sof = (m_pos == 1);
        end
        case (m_st)
            0: if (m) begin
                m_hits = 1; m_pos = 1; m_miss = 0;
                m_st = (LC == 1) ? 2 : 1;
            end
            1: begin
                if (m_pos == 0) begin
                    if (m) begin
                        m_hits++;
                        if (m_hits == LC) begin m_st = 2; m_miss = 0; end
                    end else m_st = 0;
                end
                m_pos = (m_st == 0) ? 0 : (m_pos + 1) % FW;
            end
            default: begin
                if (m_pos == 0) begin
                    if (m_fc < 65535) m_fc++;
                    if (m) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss == MC) begin m_st = 0; m_out.ll = 1'b1; m_fc = 0; end
                    end
                end
                m_pos = (m_st == 0) ? 0 : (m_pos + 1) % FW;
            end
        endcase
        m_out.lk = (m_st == 2);
        m_out.fc = (FC_STEP != 0) ? 16'(m_fc) : 16'd0;
    endtask

    task automatic step(input bit r, input bit m, input logic [31:0] d);
        exp_t e;
        rst = r; match = m; i = d;
        model_step(r, m, d);
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("o",         64'(o),         64'(e.o));
            chk("o_valid",   64'(o_valid),   64'(e.v));
            chk("sof",       64'(sof),       64'(e.sof));
            chk("word_idx",  64'(word_idx),  64'(e.idx));
            chk("locked",    64'(locked),    64'(e.lk));
            chk("lock_lost", 64'(lock_lost), 64'(e.ll));
            chk("frame_cnt", 64'(frame_cnt), 64'(e.fc));
        end
    endtask

    int rise, sof_at, lost_n, lost_at, unlock_n, fc0, fc1;

    initial begin
        rst = 1'b1; match = 1'b0; i = '0;

        // Reset with match asserted: outputs must be cleared
        for (int c = 0; c < 2; c++) step(1'b1, 1'b1, 32'hDEADBEEF);
        chk("rst_all_zero", 64'({o, o_valid, sof, word_idx, locked, lock_lost, frame_cnt}), 64'd0);

        // Acquire: syncs every 4 words from cycle 0
        rise = -1; sof_at = -1;
        for (int c = 0; c <= 16; c++) begin
            step(1'b0, (c % 4 == 0), 32'(c));
            if (locked && rise < 0) rise = c + 1;
            if (sof && sof_at < 0) sof_at = c + 1;
            if (c == 9) chk("acq_first_payload", 64'(o), 64'd9);
        end
        chk("acq_lock_cycle", 64'(rise), 64'd9);
        chk("acq_sof_cycle", 64'(sof_at), 64'd10);

        // False start: stray match at 2, missing sync at 4, real stream from 5
        for (int c = 0; c < 2; c++) step(1'b1, 1'b0, 32'h0);
        rise = -1;
        for (int c = 0; c <= 20; c++) begin
            step(1'b0, (c inside {0, 2, 5, 9, 13, 17}), 32'(c + 100));
            if (locked && rise < 0) rise = c + 1;
        end
        chk("fs_lock_cycle", 64'(rise), 64'd14);

        // Flywheel: miss 21, hit 25, miss 29, hit 33
        fc0 = frame_cnt; fc1 = 0; lost_n = 0; unlock_n = 0;
        for (int c = 21; c <= 36; c++) begin
            step(1'b0, (c % 4 == 1) && !(c == 21 || c == 29), $urandom);
            if (lock_lost) lost_n++;
            if (!locked) unlock_n++;
            if (c == 32) fc1 = frame_cnt;
        end
        chk("fly_no_lost", 64'(lost_n), 64'd0);
        chk("fly_stay_locked", 64'(unlock_n), 64'd0);
        chk("fly_fc_delta", 64'(fc1 - fc0), 64'(3 * FC_STEP));

        // Loss: two consecutive missed syncs at 37 and 41, no matches afterwards
        lost_n = 0; lost_at = -1;
        for (int c = 37; c <= 50; c++) begin
            step(1'b0, 1'b0, $urandom);
            if (lock_lost) begin lost_n++; lost_at = c + 1; end
            if (c == 41) chk("loss_locked_low", 64'(locked), 64'd0);
        end
        chk("loss_pulse_count", 64'(lost_n), 64'd1);
        chk("loss_pulse_cycle", 64'(lost_at), 64'd42);
        chk("loss_fc_zero", 64'(frame_cnt), 64'd0);

        // Random stream with mostly-periodic syncs, spurious matches and a mid-lock reset
        for (int c = 0; c < 2; c++) step(1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 300; c++) begin
            step((c == 150), (c % 4 == 0) ? ($urandom_range(0, 9) != 0)
                                          : ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
